vmult_pipe: RTL and testbench
=============================

Name: vmult_pipe

Overview:
- Pipelined, parametrised N-lane IEEE-754 binary16 multiplier for the vector datapath. It is the clocked successor to the single-lane combinational multiplier.
- Each lane computes A[i]*B[i] with correct round-to-nearest-even, including subnormal operands and subnormal results.
- Lanes issue together under a valid/ready handshake and emerge after a fixed 3-cycle latency.
- Also provides per-lane overflow flags and a sticky overflow status for the vector status register.

Parameters:
- LANES, 4, number of independent FP16 lanes (1..16).
- W, 16, element width; fixed at 16 for this generation, and any other value is an elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  pipeline can accept an operand vector this cycle.
- a  input  LANES*W  operand A; lane i occupies bits [16i+15:16i].
- b  input  LANES*W  operand B; same packing as a.
- out_valid  output  1  result vector valid.
- out_ready  input  1  consumer accepts the result.
- product  output  LANES*W  result vector; same packing as a.
- ovf  output  LANES  per-lane overflow flag, aligned with product.
- ovf_sticky  output  1  OR of all ovf bits accepted by the consumer since the last clear.
- ovf_clr  input  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all stage valid bits, out_valid and ovf_sticky clear to 0.
  - product and ovf clear to 0.
  - Any operations in flight are discarded and never appear at the output.
- Pipeline stages; each holds a valid bit:
  - S1: unpack. Hidden bit is 1 when exp!=0, else 0. Effective exponent is max(exp,1). Form the 11x11 mantissa product (22 bits) and the 7-bit signed exponent sum eA+eB-15.
  - S2: normalise. If product bit 21 is set, shift right 1 and increment the exponent. Otherwise left-shift by the leading-zero count, limited so the exponent stays >=1. If the exponent is <1, right-shift by (1-exp), clamp the exponent to 1, and OR all shifted-out bits into sticky.
  - S3: round and pack. Use guard bit G, round bit R and sticky S. Increment when G & (R|S|lsb). A carry out of the mantissa increments the exponent. A result with exponent 1 and hidden bit 0 packs with exp field 0. Result sign is sA^sB.
- Latency: exactly 3 clk edges from acceptance to out_valid when never stalled.
- Throughput: 1 vector/cycle.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance; it is combinational from out_ready.
  - When advance=1, every stage shifts forward. S1 loads in_valid & in_ready.
  - When advance=0, all stage registers hold and out_valid, product and ovf remain stable.
  - Bubbles are not collapsed.
  - A transfer occurs on in_valid & in_ready (input side) or out_valid & out_ready (output side).
- Overflow: a rounded exponent >30 yields ±Inf (exp 31, mantissa 0) with ovf[i]=1.
- Underflow: a product below the smallest subnormal rounds per RNE to ±0 or ±0x0001. ovf[i]=0.
- Zero: any zero operand gives a signed zero; −0 is preserved.
- ovf_sticky:
  - Set on an output transfer with |ovf=1.
  - ovf_clr=1 clears it. If clear and set occur in the same cycle, set wins.
  - ovf_sticky is not otherwise affected by stalls.

Optional Feature:
- Macro: VMULT_PIPE_SPECIALS_EN.
- Defined: exp=31 inputs follow IEEE rules.
  - Either operand NaN → 0x7E00.
  - Inf*0 → 0x7E00.
  - Inf*finite nonzero → ±Inf with ovf=0.
  - Only finite overflow sets ovf.
- Undefined: exp=31 inputs are treated as ordinary finite values with exponent 31. They typically overflow to ±Inf with ovf=1. No NaN is ever produced.

Test Plan:
- Lane0 a=0x3C00, b=0x3C00; lane1 a=0xBC00, b=0x3C00 → after 3 cycles product lanes 0x3C00 and 0xBC00, ovf=0.
- Subnormal lanes:
  - 0x4080*0x0201 → 0x0482
  - 0x3C80*0x0201 → 0x0241
  - 0x4080*0x0011 → 0x0026
  - 0x0001*0x0001 → 0x0000
- 0x7AAA*0x7ADE → 0x7C00, ovf=1, ovf_sticky=1 after the output transfer. Pulse ovf_clr → ovf_sticky=0.
- Stall test:
  - Stream 6 vectors back-to-back.
  - Hold out_ready=0 for 4 cycles after the first output → in_ready=0, output held stable.
  - Release → all 6 results in order, none lost or duplicated.
- Drop rst_n mid-stream with 2 vectors in flight → out_valid=0 immediately. After release, no stale result appears.
- With VMULT_PIPE_SPECIALS_EN:
  - 0x7C00*0x0000 → 0x7E00, ovf=0
  - 0xFC00*0x3C00 → 0xFC00, ovf=0
  - Without the macro, 0x7C00*0x3C00 → 0x7C00, ovf=1.

Source files
------------

// File: rtl/vmult_pipe.sv
// vmult_pipe: LANES-wide pipelined IEEE-754 binary16 multiplier.
// Three register stages: unpack/multiply, normalise, round/pack. The
// round-to-nearest-even rounding also covers subnormal operands and results.
// A valid/ready handshake stalls every stage together.
// Define VMULT_PIPE_SPECIALS_EN to give exponent-31 inputs IEEE NaN/Inf
// semantics. Without it they are treated as finite values with exponent 31.
module vmult_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] product,
    output logic [LANES-1:0]   ovf,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);

    if (W != 16) begin : g_w_check
        $error("vmult_pipe: W must be 16");
    end
    if (LANES < 1 || LANES > 16) begin : g_lanes_check
        $error("vmult_pipe: LANES must be in 1..16");
    end

    // Leading-zero count of a 21-bit value measured from bit 20 (21 when zero).
    function automatic logic [4:0] lzc21(input logic [20:0] v);
        logic [4:0] n;
        n = 5'd21;
        for (int unsigned i = 0; i < 21; i++) begin
            if (v[i]) n = 5'(20 - i);
        end
        return n;
    endfunction

    logic w_adv;
    logic r_s1_valid, r_s2_valid, r_s3_valid;
    logic r_sticky;

    assign w_adv      = ~r_s3_valid | out_ready;
    assign in_ready   = w_adv;
    assign out_valid  = r_s3_valid;
    assign ovf_sticky = r_sticky;

    // Stage valid bits shift together on advance; bubbles travel with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // Sticky overflow: set by an accepted result with any ovf bit; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_s3_valid && out_ready && (|ovf)) begin
            r_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_sticky <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [15:0]       w_a, w_b;
        logic [4:0]        w_ea, w_eb;
        logic [10:0]       w_ma, w_mb;
        logic [21:0]       w_mprod;
        logic signed [6:0] w_esum;

        logic              r_s1_sign;
        logic [21:0]       r_s1_mant;
        logic signed [6:0] r_s1_exp;

        logic [21:0]       w_nm, w_mask;
        logic signed [6:0] w_ne, w_lz, w_lim, w_sh;
        logic [4:0]        w_rs;
        logic              w_nst;

        logic              r_s2_sign, r_s2_st;
        logic [20:0]       r_s2_mant;
        logic signed [6:0] r_s2_exp;

        logic              w_inc, w_ovf;
        logic [11:0]       w_sum;
        logic [10:0]       w_rm;
        logic signed [6:0] w_re;
        logic [15:0]       w_res;

        logic [15:0]       r_s3_prod;
        logic              r_s3_ovf;

        assign w_a     = a[W*gi +: W];
        assign w_b     = b[W*gi +: W];
        assign w_ea    = (w_a[14:10] == 5'd0) ? 5'd1 : w_a[14:10];
        assign w_eb    = (w_b[14:10] == 5'd0) ? 5'd1 : w_b[14:10];
        assign w_ma    = {|w_a[14:10], w_a[9:0]};
        assign w_mb    = {|w_b[14:10], w_b[9:0]};
        assign w_mprod = {11'd0, w_ma} * {11'd0, w_mb};
        assign w_esum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 7'sd15;

`ifdef VMULT_PIPE_SPECIALS_EN
        logic w_a_max, w_b_max, w_a_zero, w_b_zero, w_nan, w_inf;
        logic r_s1_nan, r_s1_inf, r_s2_nan, r_s2_inf;

        assign w_a_max  = &w_a[14:10];
        assign w_b_max  = &w_b[14:10];
        assign w_a_zero = (w_a[14:0] == 15'd0);
        assign w_b_zero = (w_b[14:0] == 15'd0);
        assign w_nan    = (w_a_max & (|w_a[9:0])) | (w_b_max & (|w_b[9:0]))
                        | (w_a_max & w_b_zero) | (w_b_max & w_a_zero);
        assign w_inf    = (w_a_max | w_b_max) & ~w_nan;

        // Special-operand class follows its lane through the pipeline.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_nan <= 1'b0;
                r_s1_inf <= 1'b0;
                r_s2_nan <= 1'b0;
                r_s2_inf <= 1'b0;
            end else if (w_adv) begin
                r_s1_nan <= w_nan;
                r_s1_inf <= w_inf;
                r_s2_nan <= r_s1_nan;
                r_s2_inf <= r_s1_inf;
            end
        end
`endif

        // S1: unpacked sign, 22-bit mantissa product and biased exponent sum.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_sign <= 1'b0;
                r_s1_mant <= '0;
                r_s1_exp  <= '0;
            end else if (w_adv) begin
                r_s1_sign <= w_a[15] ^ w_b[15];
                r_s1_mant <= w_mprod;
                r_s1_exp  <= w_esum;
            end
        end

        // Normalise so the hidden bit sits at bit 20; denormalise into sticky if exp < 1.
        always_comb begin
            w_nm   = r_s1_mant;
            w_ne   = r_s1_exp;
            w_nst  = 1'b0;
            w_lz   = $signed({2'b00, lzc21(r_s1_mant[20:0])});
            w_lim  = '0;
            w_sh   = '0;
            w_rs   = '0;
            w_mask = '0;
            if (w_nm[21]) begin
                w_nst = w_nm[0];
                w_nm  = w_nm >> 1;
                w_ne  = w_ne + 7'sd1;
            end else begin
                w_lim = (w_ne > 7'sd1) ? (w_ne - 7'sd1) : 7'sd0;
                w_sh  = (w_lz < w_lim) ? w_lz : w_lim;
                w_nm  = w_nm << w_sh[4:0];
                w_ne  = w_ne - w_sh;
            end
            if (w_ne < 7'sd1) begin
                w_rs   = 5'(7'sd1 - w_ne);
                w_mask = (22'd1 << w_rs) - 22'd1;
                w_nst  = w_nst | (|(w_nm & w_mask));
                w_nm   = w_nm >> w_rs;
                w_ne   = 7'sd1;
            end
        end

        // S2: normalised mantissa, exponent (>= 1) and sticky.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_sign <= 1'b0;
                r_s2_mant <= '0;
                r_s2_exp  <= '0;
                r_s2_st   <= 1'b0;
            end else if (w_adv) begin
                r_s2_sign <= r_s1_sign;
                r_s2_mant <= w_nm[20:0];
                r_s2_exp  <= w_ne;
                r_s2_st   <= w_nst;
            end
        end

        // Round to nearest even, detect overflow and pack the binary16 result.
        always_comb begin
            w_res = '0;
            w_ovf = 1'b0;
            w_inc = r_s2_mant[9] & (r_s2_mant[8] | (|r_s2_mant[7:0]) | r_s2_st | r_s2_mant[10]);
            w_sum = {1'b0, r_s2_mant[20:10]} + {11'd0, w_inc};
            w_rm  = w_sum[11] ? w_sum[11:1] : w_sum[10:0];
            w_re  = w_sum[11] ? (r_s2_exp + 7'sd1) : r_s2_exp;
            if (w_re > 7'sd30) begin
                w_res = {r_s2_sign, 5'h1F, 10'h000};
                w_ovf = 1'b1;
            end else begin
                w_res = {r_s2_sign, (w_rm[10] ? w_re[4:0] : 5'd0), w_rm[9:0]};
            end
`ifdef VMULT_PIPE_SPECIALS_EN
            if (r_s2_nan) begin
                w_res = 16'h7E00;
                w_ovf = 1'b0;
            end else if (r_s2_inf) begin
                w_res = {r_s2_sign, 5'h1F, 10'h000};
                w_ovf = 1'b0;
            end
`endif
        end

        // S3: output registers; only a real vector replaces the held result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s3_prod <= '0;
                r_s3_ovf  <= 1'b0;
            end else if (w_adv && r_s2_valid) begin
                r_s3_prod <= w_res;
                r_s3_ovf  <= w_ovf;
            end
        end

        assign product[W*gi +: W] = r_s3_prod;
        assign ovf[gi]            = r_s3_ovf;
    end

endmodule

// File: tb/tb_vmult_pipe.sv
// Testbench for vmult_pipe (4 lanes): directed vector table plus stall,
// sticky-overflow and mid-stream reset sequences.
module tb_vmult_pipe;

    localparam int unsigned LANES = 4;
    localparam int unsigned W     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LANES*W-1:0] a;
    logic [LANES*W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [LANES*W-1:0] product;
    logic [LANES-1:0]  ovf;
    logic              ovf_sticky;
    logic              ovf_clr;

    always #5 clk = ~clk;

    vmult_pipe #(.LANES(LANES), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] p;
        logic [3:0]  ovf;
    } vec_t;

    vec_t        tbl[5];
    logic [63:0] exp_v[6];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, got, stall;
        bit   first, acc, stale;

        // Lane 0 in the low 16 bits.
        tbl[0] = '{a: {16'h3C80, 16'h4080, 16'hBC00, 16'h3C00},
                   b: {16'h0201, 16'h0201, 16'h3C00, 16'h3C00},
                   p: {16'h0241, 16'h0482, 16'hBC00, 16'h3C00}, ovf: 4'b0000};
        tbl[1] = '{a: {16'h0001, 16'h8000, 16'h0001, 16'h4080},
                   b: {16'h3A00, 16'h3C00, 16'h0001, 16'h0011},
                   p: {16'h0001, 16'h8000, 16'h0000, 16'h0026}, ovf: 4'b0000};
        tbl[2] = '{a: {16'h03FF, 16'h3FFF, 16'h3E00, 16'h3E00},
                   b: {16'h3C01, 16'h3FFF, 16'h3C03, 16'h3C01},
                   p: {16'h0400, 16'h43FE, 16'h3E04, 16'h3E02}, ovf: 4'b0000};
        tbl[3] = '{a: {16'h0001, 16'h0003, 16'h7BFF, 16'h7AAA},
                   b: {16'h3800, 16'h3800, 16'h3C00, 16'h7ADE},
                   p: {16'h0000, 16'h0002, 16'h7BFF, 16'h7C00}, ovf: 4'b0001};
`ifdef VMULT_PIPE_SPECIALS_EN
        tbl[4] = '{a: {16'h7BFF, 16'hFC00, 16'h7C00, 16'h7C00},
                   b: {16'h3C01, 16'h3C00, 16'h0000, 16'h3C00},
                   p: {16'h7C00, 16'hFC00, 16'h7E00, 16'h7C00}, ovf: 4'b1000};
`else
        tbl[4] = '{a: {16'h7BFF, 16'hFC00, 16'h7C00, 16'h7C00},
                   b: {16'h3C01, 16'h3C00, 16'h0000, 16'h3C00},
                   p: {16'h7C00, 16'hFC00, 16'h0000, 16'h7C00}, ovf: 4'b1101};
`endif
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) exp_v[k][16*i +: 16] = 16'h4000 + 16'(k*16 + i);
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        a = '0; b = '0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_product", product, 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_sticky", 64'(ovf_sticky), 64'd0);
        #10 rst_n = 1'b1;

        // Table: one vector at a time, latency and result checked.
        for (int r = 0; r < 5; r++) begin
            a = tbl[r].a; b = tbl[r].b; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("row%0d_in_ready", r), 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("row%0d_valid_early", r), 64'(out_valid), 64'd0);
            tick();
            chk($sformatf("row%0d_valid", r), 64'(out_valid), 64'd1);
            chk($sformatf("row%0d_product", r), product, tbl[r].p);
            chk($sformatf("row%0d_ovf", r), 64'(ovf), 64'(tbl[r].ovf));
            tick();
        end
        chk("sticky_after_table", 64'(ovf_sticky), 64'd1);

        // Sticky: clear, hold under stall, set wins over simultaneous clear.
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("sticky_cleared", 64'(ovf_sticky), 64'd0);
        a = tbl[3].a; b = tbl[3].b; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        chk("sticky_vec_valid", 64'(out_valid), 64'd1);
        chk("sticky_no_xfer", 64'(ovf_sticky), 64'd0);
        tick();
        chk("sticky_stall_hold", 64'(ovf_sticky), 64'd0);
        chk("stall_product_hold", product, tbl[3].p);
        ovf_clr = 1'b1; out_ready = 1'b1;
        tick();
        chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        tick();
        chk("sticky_clear_again", 64'(ovf_sticky), 64'd0);
        ovf_clr = 1'b0;

        // Stream 6 vectors, stall the consumer for 4 cycles after the first output.
        sent = 0; got = 0; stall = 0; first = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid = (sent < 6);
            for (int i = 0; i < 4; i++) begin
                a[16*i +: 16] = 16'h3C00;
                b[16*i +: 16] = 16'h4000 + 16'(sent*16 + i);
            end
            out_ready = !(first && stall < 4);
            #1;
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_hold", product, exp_v[got]);
                stall++;
            end else if (out_valid) begin
                chk($sformatf("stream_out%0d", got), product, exp_v[got]);
                got++;
                first = 1'b1;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(got), 64'd6);
        tick(); tick();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Mid-stream reset with one result visible and two in flight.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = exp_v[k];
            for (int i = 0; i < 4; i++) a[16*i +: 16] = 16'h3C00;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'd0);
        chk("async_reset_product", product, 64'd0);
        chk("async_reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        chk("no_stale_after_reset", 64'(stale), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
